// File: rtl/regs_wb_pkg.sv
// Shared constants for the regfile writeback arbiter.
// Address/data width defaults, zero register, port indices.
package regs_wb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Two writeback request ports into the regfile arbiter.
// Sources use master, the arbiter uses slave.
interface regs_wb_arbiter_if #(
  parameter int AW = regs_wb_pkg::AW,
  parameter int DW = regs_wb_pkg::DW
);
  logic          p0_valid;
  logic          p0_ready;
  logic [AW-1:0] p0_wreg;
  logic [DW-1:0] p0_wdata;
  logic          p1_valid;
  logic          p1_ready;
  logic [AW-1:0] p1_wreg;
  logic [DW-1:0] p1_wdata;

  modport master (
    output p0_valid, p0_wreg, p0_wdata,
    output p1_valid, p1_wreg, p1_wdata,
    input  p0_ready, p1_ready
  );

  modport slave (
    input  p0_valid, p0_wreg, p0_wdata,
    input  p1_valid, p1_wreg, p1_wdata,
    output p0_ready, p1_ready
  );
endinterface

// File: rtl/regs_wb_arbiter_scoreboard.sv
// Busy bit per register for outstanding port-1 writes.
// Set beats clear on the same register; bit 0 never set.
module wb_scoreboard #(
  parameter int AW = regs_wb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_reg,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_reg,
  input  logic [AW-1:0] qa,
  input  logic [AW-1:0] qb,
  output logic          busy_a,
  output logic          busy_b
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;

  // next busy vector: clear first so a same-cycle set wins
  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_reg] = 1'b0;
    if (set_en) busy_n[set_reg] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // busy vector register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  assign busy_a = busy[qa];
  assign busy_b = busy[qb];
endmodule

// File: rtl/regs_wb_arbiter.sv
// Regfile write-port arbiter with port-1 busy scoreboard.
// WB_RR_ARB_EN selects round-robin on contention.
module regs_wb_arbiter
  import regs_wb_pkg::REG_ZERO, regs_wb_pkg::P0, regs_wb_pkg::P1;
#(
  parameter int AW = regs_wb_pkg::AW,
  parameter int DW = regs_wb_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  regs_wb_arbiter_if.slave     wb,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_reg,
  input  logic [AW-1:0]        rreg_a,
  input  logic [AW-1:0]        rreg_b,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 RegWrite,
  output logic [AW:0]          wreg,
  output logic [DW-1:0]        wdata
);
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic          g0;
  logic          g1;
  logic          xfer;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;
  logic          sb_a;
  logic          sb_b;

`ifdef WB_RR_ARB_EN
  logic ptr;

  // grant: alternate under contention, else whoever asks
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (wb.p0_valid && wb.p1_valid) begin
        g0 = (ptr == P0);
        g1 = (ptr == P1);
      end else begin
        g0 = wb.p0_valid;
        g1 = wb.p1_valid;
      end
    end
  end

  // pointer flips only after a contended grant
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= P0;
    else if (wb.p0_valid && wb.p1_valid)
      ptr <= ~ptr;
  end
`else
  // grant: port 1 always beats port 0
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      g1 = wb.p1_valid;
      g0 = wb.p0_valid && !wb.p1_valid;
    end
  end
`endif

  assign wb.p0_ready = g0;
  assign wb.p1_ready = g1;
  assign xfer        = g0 | g1;
  assign sel_reg     = g1 ? wb.p1_wreg  : wb.p0_wreg;
  assign sel_data    = g1 ? wb.p1_wdata : wb.p0_wdata;

  // register the winner onto the write bus; r0 accepted but not written
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else if (xfer) begin
      RegWrite <= (sel_reg != RZ);
      wreg     <= {1'b0, sel_reg};
      wdata    <= sel_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  wb_scoreboard #(.AW(AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (alloc_valid),
    .set_reg (alloc_reg),
    .clr_en  (g1),
    .clr_reg (wb.p1_wreg),
    .qa      (rreg_a),
    .qb      (rreg_b),
    .busy_a  (sb_a),
    .busy_b  (sb_b)
  );

  // a write still on the bus is not yet visible in the regfile
  assign busy_a = sb_a | (RegWrite && wreg[AW-1:0] == rreg_a && rreg_a != RZ);
  assign busy_b = sb_b | (RegWrite && wreg[AW-1:0] == rreg_b && rreg_b != RZ);
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed cases then random traffic.
// Driver pushes expectations, monitor pops and compares.
module tb_regs_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regs_wb_arbiter_if wb ();
  logic        alloc_valid;
  logic [4:0]  alloc_reg;
  logic [4:0]  rreg_a;
  logic [4:0]  rreg_b;
  logic        busy_a;
  logic        busy_b;
  logic        RegWrite;
  logic [5:0]  wreg;
  logic [31:0] wdata;

  regs_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb.slave),
    .alloc_valid (alloc_valid),
    .alloc_reg   (alloc_reg),
    .rreg_a      (rreg_a),
    .rreg_b      (rreg_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .RegWrite    (RegWrite),
    .wreg        (wreg),
    .wdata       (wdata)
  );

  typedef struct {
    bit          r;
    bit          p0v;
    logic [4:0]  p0r;
    logic [31:0] p0d;
    bit          p1v;
    logic [4:0]  p1r;
    logic [31:0] p1d;
    bit          av;
    logic [4:0]  ar;
    logic [4:0]  qa;
    logic [4:0]  qb;
  } stim_t;

  typedef struct {
    bit          r0;
    bit          r1;
    bit          ba;
    bit          bb;
    bit          rw;
    bit          known;
    logic [5:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // reference state: what the regfile side should see
  bit          pend_busy[32];
  bit          m_rw = 0;
  logic [5:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  bit          m_known = 1;
  bit          m_turn_p1 = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // called at negedge: drive, predict, advance model, wait a cycle
  task automatic step(input stim_t s, output bit g0, output bit g1);
    exp_t e;
    logic [4:0] w;
    logic [31:0] d;
    rst = s.r;
    wb.p0_valid = s.p0v; wb.p0_wreg = s.p0r; wb.p0_wdata = s.p0d;
    wb.p1_valid = s.p1v; wb.p1_wreg = s.p1r; wb.p1_wdata = s.p1d;
    alloc_valid = s.av; alloc_reg = s.ar;
    rreg_a = s.qa; rreg_b = s.qb;
    g0 = 0; g1 = 0;
    if (!s.r) begin
      if (s.p0v && s.p1v) begin
        g1 = RR ? m_turn_p1 : 1'b1;
        g0 = !g1;
      end else begin
        g0 = s.p0v;
        g1 = s.p1v;
      end
    end
    e.r0 = g0; e.r1 = g1;
    e.ba = (s.qa != 0) && (pend_busy[s.qa] || (m_rw && m_wr == {1'b0, s.qa}));
    e.bb = (s.qb != 0) && (pend_busy[s.qb] || (m_rw && m_wr == {1'b0, s.qb}));
    e.rw = m_rw; e.wr = m_wr; e.wd = m_wd; e.known = m_known;
    exp_q.push_back(e);
    if (s.r) begin
      foreach (pend_busy[i]) pend_busy[i] = 0;
      m_rw = 0; m_wr = '0; m_wd = '0; m_known = 1; m_turn_p1 = 0;
    end else begin
      if (g0 || g1) begin
        w = g1 ? s.p1r : s.p0r;
        d = g1 ? s.p1d : s.p0d;
        m_rw = (w != 0);
        if (w != 0) begin
          m_wr = {1'b0, w}; m_wd = d; m_known = 1;
        end else begin
          m_known = 0;
        end
      end else begin
        m_rw = 0;
      end
      if (g1) pend_busy[s.p1r] = 0;
      if (s.av && s.ar != 0) pend_busy[s.ar] = 1;
      if (RR && s.p0v && s.p1v) m_turn_p1 = !m_turn_p1;
    end
    @(negedge clk);
  endtask

  // monitor: compare every cycle's outputs against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
          e = exp_q.pop_front();
          chk("p0_ready", 32'(wb.p0_ready), 32'(e.r0));
          chk("p1_ready", 32'(wb.p1_ready), 32'(e.r1));
          chk("busy_a", 32'(busy_a), 32'(e.ba));
          chk("busy_b", 32'(busy_b), 32'(e.bb));
          chk("RegWrite", 32'(RegWrite), 32'(e.rw));
          if (e.known) begin
            chk("wreg", 32'(wreg), 32'(e.wr));
            chk("wdata", wdata, e.wd);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit g0, g1;
    bit h0, h1;
    logic [4:0] r0, r1;
    logic [31:0] d0, d1;
    foreach (pend_busy[i]) pend_busy[i] = 0;
    s = idle();
    s.r = 1;
    rst = 1; wb.p0_valid = 0; wb.p1_valid = 0;
    wb.p0_wreg = '0; wb.p1_wreg = '0; wb.p0_wdata = '0; wb.p1_wdata = '0;
    alloc_valid = 0; alloc_reg = '0; rreg_a = '0; rreg_b = '0;
    @(negedge clk);
    step(s, g0, g1);
    step(s, g0, g1);

    s = idle(); s.p0v = 1; s.p0r = 3; s.p0d = 32'h11;
    step(s, g0, g1);
    step(idle(), g0, g1);

    h0 = 1; h1 = 1;
`ifdef WB_RR_ARB_EN
    for (int i = 0; i < 4; i++) begin
      s = idle();
      s.p0v = 1; s.p0r = 4; s.p0d = 32'hA;
      s.p1v = 1; s.p1r = 5; s.p1d = 32'hB;
      step(s, g0, g1);
    end
`else
    for (int i = 0; i < 3; i++) begin
      s = idle();
      s.p0v = h0; s.p0r = 4; s.p0d = 32'hA;
      s.p1v = h1; s.p1r = 5; s.p1d = 32'hB;
      step(s, g0, g1);
      if (g0) h0 = 0;
      if (g1) h1 = 0;
    end
`endif
    step(idle(), g0, g1);

    s = idle(); s.av = 1; s.ar = 7; s.qa = 7;
    step(s, g0, g1);
    s = idle(); s.qa = 7;
    step(s, g0, g1);
    s.p1v = 1; s.p1r = 7; s.p1d = 32'h77;
    step(s, g0, g1);
    s = idle(); s.qa = 7;
    step(s, g0, g1);
    step(s, g0, g1);

    s = idle(); s.av = 1; s.ar = 9; s.qb = 9;
    s.p1v = 1; s.p1r = 9; s.p1d = 32'h99;
    step(s, g0, g1);
    s = idle(); s.qb = 9;
    step(s, g0, g1);
    step(s, g0, g1);
    s = idle(); s.av = 1; s.ar = 0; s.qa = 0;
    step(s, g0, g1);
    step(s, g0, g1);

    s = idle(); s.p0v = 1; s.p0r = 0; s.p0d = 32'hDEAD;
    step(s, g0, g1);
    s = idle(); s.av = 1; s.ar = 12;
    step(s, g0, g1);
    s = idle(); s.p0v = 1; s.p0r = 6; s.p0d = 32'h66; s.qa = 12;
    step(s, g0, g1);
    s = idle(); s.r = 1; s.p0v = 1; s.p0r = 8; s.p0d = 32'h88;
    s.qa = 12; s.qb = 6;
    step(s, g0, g1);
    s = idle(); s.qa = 12; s.qb = 6;
    step(s, g0, g1);

    h0 = 0; h1 = 0;
    r0 = '0; r1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 2000; n++) begin
      s = idle();
      s.r = ($urandom_range(0, 99) == 0);
      if (!h0 && $urandom_range(0, 1) == 1) begin
        h0 = 1; r0 = 5'($urandom); d0 = $urandom;
      end
      if (!h1 && $urandom_range(0, 2) == 0) begin
        h1 = 1; r1 = 5'($urandom_range(0, 7)); d1 = $urandom;
      end
      s.p0v = h0; s.p0r = r0; s.p0d = d0;
      s.p1v = h1; s.p1r = r1; s.p1d = d1;
      s.av = ($urandom_range(0, 3) == 0);
      s.ar = 5'($urandom_range(0, 7));
      s.qa = 5'($urandom_range(0, 7));
      s.qb = 5'($urandom);
      step(s, g0, g1);
      if (g0 || s.r) h0 = 0;
      if (g1 || s.r) h1 = 0;
    end

    done = 1;
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
